// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : program_loader_pkg
//  Purpose : Shared types and constants for the boot-time program loader.
//            Holds the loader state encoding, the default frame start
//            marker and the frame field widths.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package program_loader_pkg;

  localparam logic [7:0] c_sync_byte = 8'hA5;  // default frame start marker
  localparam int         c_len_w     = 16;     // LEN field width in bits
  localparam int         c_byte_w    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // States that sit inside a frame and are therefore subject to the idle timeout.
  function automatic logic in_frame(state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_packer.sv
`default_nettype none
// ============================================================================
//  Module  : byte_word_packer
//  Purpose : Assembles four consecutive bytes (LSB first) into one XLEN-bit
//            word. o_word_valid is a combinational strobe raised together with
//            the fourth byte; o_word is the assembled word in that cycle.
//  Ports   : clk, rst          clock, asynchronous active-high reset
//            i_clear           drop any partially assembled word
//            i_byte_valid      i_byte is to be consumed this cycle
//            i_byte            incoming byte
//            o_word_valid      fourth byte of a word is present this cycle
//            o_word            {i_byte, three previously shifted bytes}
//  Rev     : 1.0  initial release
// ============================================================================
module byte_word_packer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_word_valid,
  output logic [XLEN-1:0] o_word
);

  logic [1:0]      r_cnt;
  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the word is available in the same cycle.
  logic [XLEN-9:0] r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt   <= 2'd0;
      r_shift <= '0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[XLEN-9:8]};
    end
  end

  assign o_word_valid = i_byte_valid && !i_clear && (r_cnt == 2'd3);
  assign o_word       = {i_byte, r_shift};

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module  : program_loader
//  Purpose : Receives a framed byte stream (SYNC, LEN_LO, LEN_HI, LEN words
//            little-endian, CSUM), writes each word into instruction memory
//            over the debug write port and keeps the core in reset until a
//            complete image with a good checksum has been loaded.
//  Ports   : clk, rst      clock, asynchronous active-high reset
//            rx_valid      one-cycle byte strobe from the UART receiver
//            rx_data       received byte
//            dbg_wr_en     registered write strobe, one cycle per word
//            dbg_addr      byte address of the word being written
//            dbg_instr     word being written
//            core_rst      core reset, low only while the image is verified
//            load_done     image loaded and checksum good
//            load_error    frame aborted (length, checksum or timeout)
//  Rev     : 1.0  initial release
// ============================================================================
module program_loader
  import program_loader_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] BASE_ADDR      = '0,
  parameter logic [7:0]      SYNC_BYTE      = c_sync_byte,
  parameter int              MAX_WORDS      = 1024,
  parameter int              TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            dbg_wr_en,
  output logic [XLEN-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_instr,
  output logic            core_rst,
  output logic            load_done,
  output logic            load_error
);

  localparam int c_idle_w = $clog2(TIMEOUT_CYCLES) + 1;

  state_t               r_state;
  state_t               w_next;
  logic [c_len_w-1:0]   r_len;
  logic [c_len_w-1:0]   r_word_idx;
  logic [c_byte_w-1:0]  r_csum;
  logic [c_idle_w-1:0]  r_idle;
  logic                 r_dbg_wr_en;
  logic [XLEN-1:0]      r_dbg_addr;
  logic [XLEN-1:0]      r_dbg_instr;
  logic                 r_core_rst;
  logic                 r_load_done;
  logic                 r_load_error;

  logic                 w_sync;
  logic [c_len_w-1:0]   w_len_rx;
  logic                 w_word_valid;
  logic [XLEN-1:0]      w_word;
  logic                 w_timeout;

  byte_word_packer #(
    .XLEN (XLEN)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (r_state != ST_DATA),
    .i_byte_valid (rx_valid && (r_state == ST_DATA)),
    .i_byte       (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_sync    = rx_valid && (rx_data == SYNC_BYTE);
    w_len_rx  = {rx_data, r_len[7:0]};
    w_timeout = in_frame(r_state) && !rx_valid &&
                (r_idle == c_idle_w'(TIMEOUT_CYCLES - 1));
    w_next    = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_sync) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (rx_valid) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          if (w_len_rx == '0)                         w_next = ST_CSUM;
          else if (w_len_rx > c_len_w'(MAX_WORDS))    w_next = ST_ERROR;
          else                                        w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_valid && (r_word_idx == r_len - c_len_w'(1))) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (rx_valid) w_next = (rx_data == r_csum) ? ST_DONE : ST_ERROR;
      end
      default: w_next = ST_IDLE;
    endcase
    // A stalled frame is abandoned regardless of where it stalled.
    if (w_timeout) w_next = ST_ERROR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_csum       <= '0;
      r_idle       <= '0;
      r_dbg_wr_en  <= 1'b0;
      r_dbg_addr   <= BASE_ADDR;
      r_dbg_instr  <= '0;
      r_core_rst   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_state      <= w_next;
      // Status flags follow the next state so they line up with r_state.
      r_core_rst   <= (w_next != ST_DONE);
      r_load_done  <= (w_next == ST_DONE);
      r_load_error <= (w_next == ST_ERROR);

      if (in_frame(w_next) && !rx_valid) r_idle <= r_idle + c_idle_w'(1);
      else                               r_idle <= '0;

      if (w_sync && !in_frame(r_state)) begin
        r_csum     <= '0;
        r_word_idx <= '0;
      end else if (rx_valid && (r_state == ST_LEN_LO || r_state == ST_LEN_HI ||
                                r_state == ST_DATA)) begin
        r_csum <= r_csum + rx_data;
      end

      if (rx_valid && r_state == ST_LEN_LO) r_len[7:0]  <= rx_data;
      if (rx_valid && r_state == ST_LEN_HI) r_len[15:8] <= rx_data;

      r_dbg_wr_en <= w_word_valid;
      if (w_word_valid) begin
        r_dbg_instr <= w_word;
        r_dbg_addr  <= BASE_ADDR + XLEN'({r_word_idx, 2'b00});
        r_word_idx  <= r_word_idx + c_len_w'(1);
      end
    end
  end

  assign dbg_wr_en  = r_dbg_wr_en;
  assign dbg_addr   = r_dbg_addr;
  assign dbg_instr  = r_dbg_instr;
  assign core_rst   = r_core_rst;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_program_loader
//  Purpose : Self-checking bench for program_loader. Frames are built from a
//            list of words; expected writes, checksum and final status are
//            derived from the frame contents.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_program_loader;

  localparam int          XLEN = 32;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        dbg_wr_en;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_instr;
  logic        core_rst;
  logic        load_done;
  logic        load_error;

  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt = 0;
  int          exp_pulses = 0;
  logic [31:0] fw[$];

  program_loader #(
    .XLEN           (XLEN),
    .BASE_ADDR      (BASE),
    .SYNC_BYTE      (8'hA5),
    .MAX_WORDS      (1024),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .dbg_wr_en  (dbg_wr_en),
    .dbg_addr   (dbg_addr),
    .dbg_instr  (dbg_instr),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Count every write pulse, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (dbg_wr_en === 1'b1) pulse_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err);
    chk({tag, ".load_done"},  32'(load_done),  32'(done));
    chk({tag, ".load_error"}, 32'(load_error), 32'(err));
    chk({tag, ".core_rst"},   32'(core_rst),   32'(!done));
  endtask

  // Called at a negedge; returns at the next negedge, after the byte is taken.
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    g = int'($urandom_range(maxgap, 0));
    repeat (g) step(1'b0, 8'($urandom));
    step(1'b1, b);
  endtask

  // Sends SYNC, LEN, all words in fw, then CSUM (corrupted when bad=1).
  task automatic send_frame(input string tag, input bit bad, input int maxgap);
    logic [7:0]  cs;
    logic [15:0] len;
    logic [31:0] w;
    logic [7:0]  b;
    len = 16'(fw.size());
    cs  = 8'h00;
    send_byte(8'hA5, maxgap);
    chk_status({tag, ".sync"}, 1'b0, 1'b0);
    send_byte(len[7:0], maxgap);
    cs = cs + len[7:0];
    send_byte(len[15:8], maxgap);
    cs = cs + len[15:8];
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        send_byte(b, maxgap);
        cs = cs + b;
      end
      exp_pulses++;
      chk({tag, ".wr_en"}, 32'(dbg_wr_en), 32'd1);
      chk({tag, ".addr"},  dbg_addr,       BASE + 32'(4 * i));
      chk({tag, ".instr"}, dbg_instr,      w);
    end
    send_byte(bad ? cs - 8'd1 : cs, maxgap);
    chk_status({tag, ".end"}, !bad, bad);
    chk({tag, ".pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
  endtask

  initial begin
    logic [7:0] g;
    repeat (2) @(negedge clk);
    chk("reset.wr_en", 32'(dbg_wr_en), 32'd0);
    chk("reset.addr",  dbg_addr,       BASE);
    chk("reset.instr", dbg_instr,      32'd0);
    chk_status("reset", 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 8'h00);

    // Reference frame: csum of 02 00 13 00 00 00 93 00 10 00 is B8.
    fw = '{32'h0000_0013, 32'h0010_0093};
    send_frame("planA", 1'b0, 0);
    send_frame("planB_bad", 1'b1, 0);     // CSUM B7
    send_frame("planB_recover", 1'b0, 0);

    fw = '{};
    send_frame("zero_len", 1'b0, 0);

    // Oversized length fields abort right after LEN_HI.
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h04, 0);
    chk_status("len1025", 1'b0, 1'b1);
    send_byte(8'hA5, 3); send_byte(8'hFF, 3); send_byte(8'hFF, 3);
    chk_status("lenFFFF", 1'b0, 1'b1);
    chk("len_err.pulses", 32'(pulse_cnt), 32'(exp_pulses));

    // Idle timeout mid-word: 15 idle cycles are tolerated, the 16th aborts.
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0);
    repeat (15) step(1'b0, 8'($urandom));
    chk("timeout.early", 32'(load_error), 32'd0);
    step(1'b0, 8'h00);
    chk_status("timeout", 1'b0, 1'b1);
    chk("timeout.pulses", 32'(pulse_cnt), 32'(exp_pulses));

    // Randomized frames with gaps well inside the timeout.
    for (int n = 0; n < 6; n++) begin
      int nw;
      fw = '{};
      nw = int'($urandom_range(6, 1));
      for (int i = 0; i < nw; i++) fw.push_back($urandom);
      send_frame("rand", ($urandom_range(3, 0) == 0), 4);
    end

    // Leave non-reset values on the write port, then reset mid-word.
    fw = '{32'hDEAD_BEEF, 32'h1234_5678};
    send_frame("pre_rst", 1'b0, 2);
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst.wr_en", 32'(dbg_wr_en), 32'd0);
    chk("midrst.addr",  dbg_addr,       BASE);
    chk("midrst.instr", dbg_instr,      32'd0);
    chk_status("midrst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      step(1'b1, g);
    end
    chk_status("garbage", 1'b0, 1'b0);
    chk("garbage.pulses", 32'(pulse_cnt), 32'(exp_pulses));
    fw = '{$urandom, $urandom, $urandom};
    send_frame("post_rst", 1'b0, 1);

    repeat (3) step(1'b0, 8'h00);
    chk("final.pulses", 32'(pulse_cnt), 32'(exp_pulses));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
